cla_accumulator: RTL

- Sequential byte-stream accumulator directly downstream of cla_8bit; consumes its 9-bit sum every accepted beat.
- Accepts a frame of N_SAMPLES unsigned bytes over a valid/ready input.
- Adds each byte into a running ACC_W-bit total using one internal cla_8bit instance for the low byte; its carry (sum[8]) ripples into the upper bits.
- Presents the frame total on a valid/ready output, then clears for the next frame.

---
 rtl/cla_accumulator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cla_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : cla_accumulator (with local cla_8bit)
// Brief    : Frame accumulator over a valid/ready byte stream; an 8-bit
//            carry-lookahead adder handles the low byte, its carry ripples up.
// Revision : 1.0 - initial release
// ============================================================================

module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] sum
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;
  logic       w_prop;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flat OR of generate terms gated by the propagate chain
  // above them, so no carry depends on a lower carry signal.
  always_comb begin
    w_c    = '0;
    w_prop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_prop & w_g[j]);
        w_prop   = w_prop & w_p[j];
      end
    end
  end

  assign sum = {w_c[8], w_p ^ w_c[7:0]};

endmodule

module cla_accumulator #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int C_CNT_W = $clog2(N_SAMPLES + 1);
  localparam int C_UP_W  = ACC_W - 8;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [C_CNT_W-1:0] r_cnt;
  logic [8:0]         w_sum;
  logic               w_accept;
  logic               w_last;
  logic               w_release;

  cla_8bit u_cla (
    .a   (r_acc[7:0]),
    .b   (in_data),
    .sum (w_sum)
  );

  assign w_accept  = in_valid && in_ready;
  assign w_last    = w_accept && (r_cnt == C_CNT_W'(N_SAMPLES - 1));
  assign w_release = (r_state == ST_DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc[7:0]       <= w_sum[7:0];
      r_acc[ACC_W-1:8] <= r_acc[ACC_W-1:8] + C_UP_W'(w_sum[8]);
      // Wrap of the upper field is the only way the total can exceed ACC_W bits.
      if ((&r_acc[ACC_W-1:8]) && w_sum[8]) r_ovf <= 1'b1;
      r_cnt <= r_cnt + C_CNT_W'(1);
    end
  end

  assign out_sum = r_acc;
  assign out_ovf = r_ovf;
  assign busy    = (r_cnt != '0) || (r_state == ST_DONE);

endmodule

`default_nettype wire
